// File: rtl/knap_search.sv
// Exhaustive 0/1 knapsack search over five fixed items: walks all 32 subsets once,
// keeping the most valuable feasible subset and counting feasible subsets above a value threshold.
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | enumerating candidates 0..31, one per enabled cycle
//   DONE  | results valid and held until the next start
module knap_search #(
  parameter int MIN_VALUE  = 15,
  parameter int MAX_WEIGHT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       en,
  output logic       busy,
  output logic       done,
  output logic [4:0] cand,
  output logic [4:0] best_set,
  output logic [6:0] best_value,
  output logic [6:0] best_weight,
  output logic [5:0] match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] MIN_V = 7'(MIN_VALUE);
  localparam logic [6:0] MAX_W = 7'(MAX_WEIGHT);

  state_t     state;
  logic [6:0] cand_value;
  logic [6:0] cand_weight;
  logic       feasible;

  // Item table: bit0=A(4,12) bit1=B(2,1) bit2=C(2,2) bit3=D(1,1) bit4=E(10,4)
  always_comb begin
    cand_value  = 7'd0;
    cand_weight = 7'd0;
    if (cand[0]) begin
      cand_value  = cand_value + 7'd4;
      cand_weight = cand_weight + 7'd12;
    end
    if (cand[1]) begin
      cand_value  = cand_value + 7'd2;
      cand_weight = cand_weight + 7'd1;
    end
    if (cand[2]) begin
      cand_value  = cand_value + 7'd2;
      cand_weight = cand_weight + 7'd2;
    end
    if (cand[3]) begin
      cand_value  = cand_value + 7'd1;
      cand_weight = cand_weight + 7'd1;
    end
    if (cand[4]) begin
      cand_value  = cand_value + 7'd10;
      cand_weight = cand_weight + 7'd4;
    end
    feasible = (cand_weight <= MAX_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cand        <= 5'd0;
      best_set    <= 5'd0;
      best_value  <= 7'd0;
      best_weight <= 7'd0;
      match_count <= 6'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            cand        <= 5'd0;
            best_set    <= 5'd0;
            best_value  <= 7'd0;
            best_weight <= 7'd0;
            match_count <= 6'd0;
          end
        end
        RUN: begin
          if (en) begin
            // Strict greater-than keeps the lower-index subset on a tie
            if (feasible && (cand_value > best_value)) begin
              best_set    <= cand;
              best_value  <= cand_value;
              best_weight <= cand_weight;
            end
            if (feasible && (cand_value > MIN_V))
              match_count <= match_count + 6'd1;
            if (cand == 5'd31) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cand <= cand + 5'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knap_search.sv
// Directed bench for knap_search: three parameterisations driven in lockstep,
// run scenarios taken from a table, plus reset-abort and hold sequences.
module tb_knap_search;

  logic clk = 1'b0;
  logic rst, start, en;

  logic       busy [3];
  logic       done [3];
  logic [4:0] cand [3];
  logic [4:0] best_set [3];
  logic [6:0] best_value [3];
  logic [6:0] best_weight [3];
  logic [5:0] match_count [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] set;
    logic [6:0] val;
    logic [6:0] wt;
    logic [5:0] mc;
  } res_t;

  typedef struct {
    int en_mode;   // 0: en held high, 1: en toggles starting low
    int start_at;  // cand value at which a stray start is pulsed, -1 for none
    int exp_busy;  // expected number of cycles with busy high
  } run_t;

  res_t exp_res [3];
  run_t runs [3];

  always #5 clk = ~clk;

  knap_search u0 (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .busy(busy[0]), .done(done[0]), .cand(cand[0]), .best_set(best_set[0]),
    .best_value(best_value[0]), .best_weight(best_weight[0]), .match_count(match_count[0])
  );

  knap_search #(.MIN_VALUE(13)) u1 (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .busy(busy[1]), .done(done[1]), .cand(cand[1]), .best_set(best_set[1]),
    .best_value(best_value[1]), .best_weight(best_weight[1]), .match_count(match_count[1])
  );

  knap_search #(.MAX_WEIGHT(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .busy(busy[2]), .done(done[2]), .cand(cand[2]), .best_set(best_set[2]),
    .best_value(best_value[2]), .best_weight(best_weight[2]), .match_count(match_count[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s u%0d busy", tag, i), int'(busy[i]), 0);
      check($sformatf("%s u%0d done", tag, i), int'(done[i]), 0);
      check($sformatf("%s u%0d cand", tag, i), int'(cand[i]), 0);
      check($sformatf("%s u%0d best_set", tag, i), int'(best_set[i]), 0);
      check($sformatf("%s u%0d best_value", tag, i), int'(best_value[i]), 0);
      check($sformatf("%s u%0d best_weight", tag, i), int'(best_weight[i]), 0);
      check($sformatf("%s u%0d match_count", tag, i), int'(match_count[i]), 0);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s u%0d done", tag, i), int'(done[i]), 1);
      check($sformatf("%s u%0d busy", tag, i), int'(busy[i]), 0);
      check($sformatf("%s u%0d best_set", tag, i), int'(best_set[i]), int'(exp_res[i].set));
      check($sformatf("%s u%0d best_value", tag, i), int'(best_value[i]), int'(exp_res[i].val));
      check($sformatf("%s u%0d best_weight", tag, i), int'(best_weight[i]), int'(exp_res[i].wt));
      check($sformatf("%s u%0d match_count", tag, i), int'(match_count[i]), int'(exp_res[i].mc));
    end
  endtask

  task automatic do_run(input int idx, input run_t r);
    int n;
    int prev;
    logic cur_en;
    start = 1'b1;
    en    = (r.en_mode == 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("run%0d entry u%0d busy", idx, i), int'(busy[i]), 1);
      check($sformatf("run%0d entry u%0d cand", idx, i), int'(cand[i]), 0);
      check($sformatf("run%0d entry u%0d best_value", idx, i), int'(best_value[i]), 0);
      check($sformatf("run%0d entry u%0d match_count", idx, i), int'(match_count[i]), 0);
    end
    n = 0;
    while (busy[0] && n < 200) begin
      if (r.en_mode == 0) begin
        check($sformatf("run%0d cand step", idx), int'(cand[0]), n);
        en = 1'b1;
      end else begin
        en = (n % 2 == 1);
      end
      start  = (r.start_at >= 0 && int'(cand[0]) == r.start_at);
      prev   = int'(cand[0]);
      cur_en = en;
      tick();
      start = 1'b0;
      n++;
      if (!cur_en && busy[0])
        check($sformatf("run%0d cand hold", idx), int'(cand[0]), prev);
      for (int i = 0; i < 3; i++)
        if (busy[i] && done[i]) check($sformatf("run%0d busy_and_done u%0d", idx, i), 1, 0);
    end
    check($sformatf("run%0d busy cycles", idx), n, r.exp_busy);
    check_results($sformatf("run%0d", idx));
  endtask

  initial begin
    int n;
    exp_res[0] = '{5'b11110, 7'd15, 7'd8, 6'd0};
    exp_res[1] = '{5'b11110, 7'd15, 7'd8, 6'd3};
    exp_res[2] = '{5'b00000, 7'd0, 7'd0, 6'd0};
    runs[0] = '{0, -1, 32};
    runs[1] = '{1, -1, 64};
    runs[2] = '{0, 5, 32};

    rst = 1'b1; start = 1'b0; en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_zero("reset");
    en = 1'b1;
    tick();
    check("idle ignores en cand", int'(cand[0]), 0);
    check("idle ignores en busy", int'(busy[0]), 0);

    for (int r = 0; r < 3; r++) begin
      do_run(r, runs[r]);
      en = 1'b1;
      tick(); tick(); tick();
      check_results($sformatf("hold%0d", r));
    end

    // Abort mid-run at cand=17, then a fresh search must still give full results
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cand[0] != 5'd17 && n < 100) begin
      tick();
      n++;
    end
    check("reach cand 17", int'(cand[0]), 17);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("abort");
    tick();
    check("abort stays idle", int'(busy[0]), 0);
    do_run(3, runs[0]);

    // rst wins over start
    rst = 1'b1; start = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_zero("rst_priority");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
